// File: rtl/fec_frame_sched.sv
// fec_frame_sched: slices a 32-bit word stream into FEC frames of DATA_WORDS
// data slots plus one parity slot. It feeds fec_gen, drives the lagged
// sof/eof strobes for fec_check and keeps frame and underrun statistics.
module fec_frame_sched #(
    parameter int                DATA_WORDS = 65,
    parameter int                WORD_W     = 32,
    parameter logic [WORD_W-1:0] IDLE_WORD  = '0,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic [WORD_W-1:0] gen_din,
    output logic              gen_parity_sel,
    output logic [6:0]        frame_word,
    output logic              rx_sof,
    output logic              rx_eof,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_count,
    output logic [CNT_W-1:0]  underrun_count
);

    localparam logic [6:0] PARITY_SLOT = 7'(DATA_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t     state;
    logic [6:0] slot;
    logic       active;
    logic       parity_slot;
    logic       out_valid;

    assign active      = (state != IDLE);
    assign parity_slot = (slot == PARITY_SLOT);
    assign in_ready    = active && (slot < PARITY_SLOT);
    assign busy        = active;

    // Run/drain control and slot sequencing; a disable only takes effect once
    // the current frame's parity slot has been issued.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
            slot  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= RUN;
                        slot  <= '0;
                    end
                end
                RUN: begin
                    slot <= parity_slot ? 7'd0 : slot + 7'd1;
                    if (!enable) begin
                        state <= parity_slot ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    slot <= parity_slot ? 7'd0 : slot + 7'd1;
                    if (enable) begin
                        state <= RUN;
                    end else if (parity_slot) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    slot  <= '0;
                end
            endcase
        end
    end

    // Output register: presents the issued slot one cycle later and derives the
    // fec_check strobes from what the gen outputs showed on the previous cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            gen_din        <= '0;
            gen_parity_sel <= 1'b0;
            frame_word     <= '0;
            out_valid      <= 1'b0;
            rx_sof         <= 1'b0;
            rx_eof         <= 1'b0;
        end else begin
            rx_sof <= out_valid && (frame_word == 7'd0) && !gen_parity_sel;
            rx_eof <= out_valid && gen_parity_sel;
            if (!active) begin
                out_valid      <= 1'b0;
                gen_din        <= '0;
                gen_parity_sel <= 1'b0;
                frame_word     <= '0;
            end else begin
                out_valid  <= 1'b1;
                frame_word <= slot;
                if (parity_slot) begin
                    gen_din        <= '0;
                    gen_parity_sel <= 1'b1;
                end else begin
                    gen_din        <= in_valid ? in_data : IDLE_WORD;
                    gen_parity_sel <= 1'b0;
                end
            end
        end
    end

    // Statistics: frames count when their parity slot is presented and wrap;
    // underruns count filler slots and stick at all-ones.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            frame_count    <= '0;
            underrun_count <= '0;
        end else if (active) begin
            if (parity_slot) begin
                frame_count <= frame_count + CNT_W'(1);
            end else if (!in_valid && (underrun_count != '1)) begin
                underrun_count <= underrun_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fec_frame_sched.sv
// tb_fec_frame_sched: directed scenarios plus a randomized phase, with every
// cycle compared against a frame-level reference model kept in the bench.
module tb_fec_frame_sched;

    localparam int          DW     = 65;
    localparam int          CW     = 8;
    localparam logic [31:0] IDLE_W = 32'h5A5A_C3C3;

    logic          clk;
    logic          arst;
    logic          enable;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          in_ready;
    logic [31:0]   gen_din;
    logic          gen_parity_sel;
    logic [6:0]    frame_word;
    logic          rx_sof;
    logic          rx_eof;
    logic          busy;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] underrun_count;

    fec_frame_sched #(
        .DATA_WORDS(DW),
        .WORD_W    (32),
        .IDLE_WORD (IDLE_W),
        .CNT_W     (CW)
    ) dut (
        .clk           (clk),
        .arst          (arst),
        .enable        (enable),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .gen_din       (gen_din),
        .gen_parity_sel(gen_parity_sel),
        .frame_word    (frame_word),
        .rx_sof        (rx_sof),
        .rx_eof        (rx_eof),
        .busy          (busy),
        .frame_count   (frame_count),
        .underrun_count(underrun_count)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int            checks;
    int            failures;
    logic [31:0]   seq_data;

    bit            m_active;
    int            m_slot;
    logic [31:0]   m_din;
    bit            m_par;
    int            m_fw;
    bit            m_shown;
    bit            m_sof;
    bit            m_eof;
    logic [CW-1:0] m_fc;
    logic [CW-1:0] m_uc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeoutCheck(input string tag, input int n, input int bound);
        checks++;
        if (n >= bound) begin
            failures++;
            $error("[TB] FAIL %s observed=timeout expected=reached", tag);
        end
    endtask

    task automatic modelReset();
        m_active = 1'b0;
        m_slot   = 0;
        m_din    = '0;
        m_par    = 1'b0;
        m_fw     = 0;
        m_shown  = 1'b0;
        m_sof    = 1'b0;
        m_eof    = 1'b0;
        m_fc     = '0;
        m_uc     = '0;
    endtask

    // One clock of the frame-level model: a running scheduler walks through
    // DW data slots and a parity slot, and only stops after a parity slot
    // issued while enable is low.
    task automatic modelStep(input bit en, input bit vld, input logic [31:0] data);
        bit nsof;
        bit neof;
        nsof = m_shown && (m_fw == 0) && !m_par;
        neof = m_shown && m_par;
        if (!m_active) begin
            m_shown = 1'b0;
            m_din   = '0;
            m_par   = 1'b0;
            m_fw    = 0;
            if (en) begin
                m_active = 1'b1;
                m_slot   = 0;
            end
        end else begin
            m_shown = 1'b1;
            m_fw    = m_slot;
            if (m_slot == DW) begin
                m_par  = 1'b1;
                m_din  = '0;
                m_fc   = m_fc + 1'b1;
                m_slot = 0;
                if (!en) m_active = 1'b0;
            end else begin
                m_par = 1'b0;
                if (vld) begin
                    m_din = data;
                end else begin
                    m_din = IDLE_W;
                    if (m_uc != {CW{1'b1}}) m_uc = m_uc + 1'b1;
                end
                m_slot = m_slot + 1;
            end
        end
        m_sof = nsof;
        m_eof = neof;
    endtask

    task automatic applyStimulus(input bit en, input bit vld, input logic [31:0] data);
        enable   = en;
        in_valid = vld;
        in_data  = data;
    endtask

    task automatic checkOutput();
        check("gen_din", gen_din, m_din);
        check("gen_parity_sel", {31'd0, gen_parity_sel}, {31'd0, m_par});
        check("frame_word", {25'd0, frame_word}, m_fw);
        check("rx_sof", {31'd0, rx_sof}, {31'd0, m_sof});
        check("rx_eof", {31'd0, rx_eof}, {31'd0, m_eof});
        check("busy", {31'd0, busy}, {31'd0, m_active});
        check("frame_count", {24'd0, frame_count}, {24'd0, m_fc});
        check("underrun_count", {24'd0, underrun_count}, {24'd0, m_uc});
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_gen_din"}, gen_din, 32'd0);
        check({tag, "_parity_sel"}, {31'd0, gen_parity_sel}, 32'd0);
        check({tag, "_frame_word"}, {25'd0, frame_word}, 32'd0);
        check({tag, "_rx_sof"}, {31'd0, rx_sof}, 32'd0);
        check({tag, "_rx_eof"}, {31'd0, rx_eof}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_frame_count"}, {24'd0, frame_count}, 32'd0);
        check({tag, "_underrun_count"}, {24'd0, underrun_count}, 32'd0);
    endtask

    // Called just after a rising edge: drives one cycle of inputs, checks the
    // combinational ready before the next edge and the registered outputs after it.
    task automatic runCycle(input bit en, input bit vld, input bit rnd);
        logic [31:0] d;
        bit          model_ready;
        d = rnd ? 32'($urandom) : seq_data;
        applyStimulus(en, vld, d);
        model_ready = m_active && (m_slot < DW);
        #3;
        check("in_ready", {31'd0, in_ready}, {31'd0, model_ready});
        if (vld && model_ready && !rnd) seq_data = seq_data + 1;
        modelStep(en, vld, d);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic runToSlot(input bit en, input bit vld, input int target);
        int n;
        n = 0;
        while (m_slot != target && n < 300) begin
            runCycle(en, vld, 1'b0);
            n++;
        end
        timeoutCheck("reach_slot", n, 300);
    endtask

    // Directed scenarios followed by randomized traffic and counter limits
    initial begin
        int n;
        checks   = 0;
        failures = 0;
        seq_data = '0;
        modelReset();
        applyStimulus(1'b0, 1'b0, 32'd0);
        arst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        arst = 1'b0;
        runCycle(1'b0, 1'b0, 1'b0);

        $display("[TB] continuous stream");
        repeat (DW + 2) runCycle(1'b1, 1'b1, 1'b0);
        check("first_frame_count", {24'd0, frame_count}, 32'd1);
        check("first_parity_word", {25'd0, frame_word}, 32'd65);
        runCycle(1'b1, 1'b1, 1'b0);
        check("resume_data", gen_din, 32'd65);
        check("resume_slot0", {25'd0, frame_word}, 32'd0);
        check("eof_after_parity", {31'd0, rx_eof}, 32'd1);

        $display("[TB] underrun slots 10-12");
        runToSlot(1'b1, 1'b1, 10);
        repeat (3) runCycle(1'b1, 1'b0, 1'b0);
        check("underrun_three", {24'd0, underrun_count}, 32'd3);
        runToSlot(1'b1, 1'b1, 0);
        check("frame_count_two", {24'd0, frame_count}, 32'd2);

        $display("[TB] disable at slot 30");
        runToSlot(1'b1, 1'b1, 30);
        runCycle(1'b0, 1'b1, 1'b0);
        check("drain_busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (m_active && n < 100) begin
            runCycle(1'b0, 1'b1, 1'b0);
            n++;
        end
        timeoutCheck("drain_done", n, 100);
        check("drain_frame_count", {24'd0, frame_count}, 32'd3);
        check("drain_idle", {31'd0, busy}, 32'd0);
        repeat (4) runCycle(1'b0, 1'b1, 1'b0);

        $display("[TB] re-enable during drain at slot 40");
        runCycle(1'b1, 1'b1, 1'b0);
        runToSlot(1'b1, 1'b1, 20);
        runToSlot(1'b0, 1'b1, 40);
        repeat (2 * (DW + 1) + 10) runCycle(1'b1, 1'b1, 1'b0);

        $display("[TB] reset mid-frame at slot 20");
        runToSlot(1'b1, 1'b1, 20);
        applyStimulus(1'b1, 1'b1, seq_data);
        #2;
        arst = 1'b1;
        #1;
        checkAllZero("async_reset");
        modelReset();
        @(posedge clk);
        #1;
        arst = 1'b0;
        repeat (3) runCycle(1'b1, 1'b1, 1'b0);
        check("sof_after_reset", {31'd0, rx_sof}, 32'd1);
        repeat (DW) runCycle(1'b1, 1'b1, 1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            runCycle($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 1'b1);
        end

        $display("[TB] underrun saturation");
        repeat (5 * (DW + 1)) runCycle(1'b1, 1'b0, 1'b0);
        check("underrun_saturated", {24'd0, underrun_count}, 32'hFF);

        $display("[TB] frame counter wrap");
        n = 0;
        while (m_fc != {CW{1'b1}} && n < 20000) begin
            runCycle(1'b1, 1'b1, 1'b0);
            n++;
        end
        check("frame_count_ff", {24'd0, frame_count}, 32'hFF);
        n = 0;
        while (m_fc == {CW{1'b1}} && n < 100) begin
            runCycle(1'b1, 1'b1, 1'b0);
            n++;
        end
        check("frame_count_wrap", {24'd0, frame_count}, 32'h0);
        check("underrun_still_sat", {24'd0, underrun_count}, 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fec_frame_sched.md
Name: fec_frame_sched

Overview:
- Frame scheduler between a 32-bit upstream word stream and the fec_gen / fec_check pair.
- Slices the stream into 2112-bit FEC frames: 65 data words, then 1 parity slot.
- Drives fec_gen din/parity_sel and back-pressures upstream during the parity slot.
- Generates the +1-lagged sof/eof strobes for fec_check, and keeps frame and underrun statistics.

Parameters:
DATA_WORDS, 65, data words per frame (frame = DATA_WORDS+1 slots)
WORD_W, 32, data word width
IDLE_WORD, 32'h0, filler word inserted when upstream has no data in a data slot
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock
arst  in  1  asynchronous active-high reset
enable  in  1  run request; sampled every cycle
in_valid  in  1  upstream word valid
in_data  in  WORD_W  upstream word
in_ready  out  1  upstream ready (combinational from state/slot)
gen_din  out  WORD_W  word to fec_gen din
gen_parity_sel  out  1  to fec_gen parity_sel; high on parity slot
frame_word  out  7  slot index of the word currently on gen_din (0..DATA_WORDS)
rx_sof  out  1  to fec_check sof; one cycle after slot 0 presented
rx_eof  out  1  to fec_check eof; one cycle after parity slot presented
busy  out  1  state != IDLE
frame_count  out  CNT_W  completed frames (parity slots presented), wraps
underrun_count  out  CNT_W  data slots filled with IDLE_WORD, saturates at all-ones

Behaviour:
- The clock is clk. Reset is asynchronous, active-high, on arst.
- Reset values:
  - state IDLE, internal slot counter 0;
  - gen_din 0, gen_parity_sel 0, frame_word 0;
  - rx_sof 0, rx_eof 0, busy 0;
  - both counters 0.
- States: IDLE, RUN, DRAIN.
- Transitions:
  - IDLE -> RUN when enable=1; slot restarts at 0.
  - RUN -> DRAIN when enable=0 sampled while slot != DATA_WORDS.
  - RUN -> IDLE when enable=0 sampled on slot == DATA_WORDS (frame completes that cycle).
  - DRAIN -> IDLE after the parity slot is issued.
  - DRAIN -> RUN if enable returns to 1 before the parity slot; the frame continues with no restart.
- Frames are never truncated. Disabling always completes the current frame, including its parity slot.
- Slot counter (RUN/DRAIN): increments each cycle, wraps DATA_WORDS -> 0. In RUN the next frame starts immediately after a parity slot, with no gap.
- in_ready = (state RUN or DRAIN) && slot < DATA_WORDS. It is 0 in IDLE and on the parity slot.
- Handshake: a word transfers when in_valid && in_ready. in_data is not consumed otherwise.
- Output register stage (1-cycle latency, slot s issued at cycle t appears on the outputs at t+1):
  - data slot with transfer: gen_din=in_data, gen_parity_sel=0;
  - data slot without in_valid: gen_din=IDLE_WORD, gen_parity_sel=0, underrun_count+1 (saturating);
  - parity slot: gen_din=0, gen_parity_sel=1;
  - frame_word = s on all issued slots.
- In IDLE the output stage holds gen_din=0, gen_parity_sel=0 and frame_word=0.
- rx_sof is a registered 1-cycle pulse the cycle after gen output shows slot 0. rx_eof is the same the cycle after gen output shows the parity slot.
- frame_count increments (mod 2^CNT_W) on the cycle the parity slot is presented on the gen outputs.
- busy = state != IDLE.
- Reset mid-frame: everything returns to its reset value immediately. The partial frame is discarded and no rx_eof is issued.
- Counters are cleared only by arst.

Test Plan:
- Continuous stream: arst pulse, enable=1, in_valid=1 with in_data incrementing from 0. Required:
  - gen_din shows 0..64 at frame_word 0..64;
  - frame_word 65 has gen_parity_sel=1 and gen_din=0;
  - in_ready=0 exactly on slot 65, and the next frame resumes at data 65;
  - frame_count=1 after 66 presented words;
  - rx_sof one cycle after frame_word=0, rx_eof one cycle after frame_word=65.
- Underrun: drop in_valid for slots 10-12 of a frame. Required: gen_din=IDLE_WORD on frame_word 10-12, underrun_count=3, and the data sequence resumes unskipped at slot 13.
- Disable mid-frame: enable=0 at slot 30. Required:
  - state DRAIN;
  - slots 31-65 still issued with parity at 65;
  - busy falls after the parity slot;
  - frame_count increments once;
  - in_ready stays 0 afterwards.
- Re-enable during DRAIN at slot 40. Required: the frame continues without restart, back-to-back frames follow, and there is no extra rx_sof.
- Reset mid-frame at slot 20. Required: all outputs and counters go to 0 asynchronously, and a new enable restarts at frame_word 0 with rx_sof.
- Saturation/wrap: force underrun_count to all-ones via a long in_valid=0 run. Required: it stays 16'hFFFF, and frame_count wraps FFFF -> 0000.
